// File: rtl/prefetch_lane_fifo_pkg.sv
// rtl/prefetch_lane_fifo_pkg.sv - push source encoding and fault-entry codes for the prefetch lane FIFO
package prefetch_lane_fifo_pkg;

`ifndef PREFETCH_DEFINES_V
`include "defines.v"
`endif

  localparam logic [3:0] GP_CODE  = `PREFETCH_GP_FAULT;
  localparam logic [3:0] PF_CODE  = `PREFETCH_PF_FAULT;
  localparam int         TYPE_LSB = `PREFETCH_TYPE_LSB;
  localparam int         TYPE_W   = 4;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LIMIT,
    SRC_PF,
    SRC_WRITE
  } push_src_e;

  function automatic logic [TYPE_W-1:0] fault_code(input push_src_e src);
    return (src == SRC_LIMIT) ? GP_CODE : PF_CODE;
  endfunction

endpackage

// File: rtl/defines.v
// rtl/defines.v - shared prefetch fault codes and length/type field position
`ifndef PREFETCH_DEFINES_V
`define PREFETCH_DEFINES_V

`define PREFETCH_GP_FAULT  4'hE
`define PREFETCH_PF_FAULT  4'hF
`define PREFETCH_TYPE_LSB  64

`endif

// File: rtl/lane_fifo_ram.sv
// rtl/lane_fifo_ram.sv - simple dual-port word store: synchronous write, asynchronous read
module lane_fifo_ram #(
  parameter int WIDTH = 138,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prefetch_lane_fifo.sv
// rtl/prefetch_lane_fifo.sv - multi-lane prefetch FIFO: word push with fault entries, per-lane consume
module prefetch_lane_fifo
  import prefetch_lane_fifo_pkg::*;
#(
  parameter int LANES = 2,
  parameter int LANE_W = 68,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pr_reset,
  input  logic                       prefetchfifo_signal_limit_do,
  input  logic                       prefetchfifo_signal_pf_do,
  input  logic                       prefetchfifo_write_do,
  input  logic [LANES*LANE_W-1:0]    prefetchfifo_write_data,
  input  logic [$clog2(LANES+1)-1:0] prefetchfifo_write_lanes,
  output logic [DEPTH_LOG2:0]        prefetchfifo_used,
  output logic                       prefetchfifo_overflow,
  output logic                       prefetchfifo_fault_locked,
  input  logic                       prefetchfifo_accept_do,
  output logic [LANE_W-1:0]          prefetchfifo_accept_data,
  output logic                       prefetchfifo_accept_empty
);

  localparam int CW = $clog2(LANES+1);
  localparam int DW = LANES*LANE_W;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [DEPTH_LOG2:0]   USED_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   USED_MAX = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [CW-1:0]         CNT_ONE  = 1;
  localparam logic [CW-1:0]         CNT_MAX  = CW'(LANES);

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         lane_idx;
  push_src_e             src;
  logic [DW-1:0]         push_data;
  logic [CW-1:0]         push_count;
  logic [DW+CW-1:0]      head_word;
  logic [CW-1:0]         head_count;
  logic                  empty, full, pop, advance, push_ok, drop_full, fault_src;

  always_comb begin
    src = SRC_NONE;
    if (prefetchfifo_signal_limit_do)     src = SRC_LIMIT;
    else if (prefetchfifo_signal_pf_do)   src = SRC_PF;
    else if (prefetchfifo_write_do && prefetchfifo_write_lanes != '0) src = SRC_WRITE;
  end

  // Fault entries occupy lane 0 only, with the fault code in the length/type field.
  always_comb begin
    push_data  = '0;
    push_count = CNT_ONE;
    if (src == SRC_WRITE) begin
      push_data  = prefetchfifo_write_data;
      push_count = (prefetchfifo_write_lanes > CNT_MAX) ? CNT_MAX : prefetchfifo_write_lanes;
    end else if (src != SRC_NONE) begin
      push_data[TYPE_LSB +: TYPE_W] = fault_code(src);
    end
  end

  lane_fifo_ram #(.WIDTH(DW+CW), .ADDR_W(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (push_ok && !pr_reset),
    .waddr (wr_ptr),
    .wdata ({push_count, push_data}),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  assign head_count = head_word[DW +: CW];
  assign empty      = (prefetchfifo_used == '0);
  assign full       = (prefetchfifo_used == USED_MAX);
  assign pop        = prefetchfifo_accept_do && !empty && (lane_idx + CNT_ONE == head_count);
  assign advance    = prefetchfifo_accept_do && !empty && !pop;
  assign fault_src  = (src == SRC_LIMIT) || (src == SRC_PF);
  // A full FIFO still takes a push when the head word leaves in the same cycle.
  assign push_ok    = (src != SRC_NONE) && !prefetchfifo_fault_locked && (!full || pop);
  assign drop_full  = (src != SRC_NONE) && !prefetchfifo_fault_locked && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr                    <= '0;
      rd_ptr                    <= '0;
      lane_idx                  <= '0;
      prefetchfifo_used         <= '0;
      prefetchfifo_overflow     <= 1'b0;
      prefetchfifo_fault_locked <= 1'b0;
    end else if (pr_reset) begin
      wr_ptr                    <= '0;
      rd_ptr                    <= '0;
      lane_idx                  <= '0;
      prefetchfifo_used         <= '0;
      prefetchfifo_overflow     <= 1'b0;
      prefetchfifo_fault_locked <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        lane_idx <= '0;
      end else if (advance) begin
        lane_idx <= lane_idx + CNT_ONE;
      end
      if (push_ok && !pop)      prefetchfifo_used <= prefetchfifo_used + USED_ONE;
      else if (!push_ok && pop) prefetchfifo_used <= prefetchfifo_used - USED_ONE;
      if (drop_full)            prefetchfifo_overflow <= 1'b1;
      if (push_ok && fault_src) prefetchfifo_fault_locked <= 1'b1;
    end
  end

  assign prefetchfifo_accept_empty = empty;
  assign prefetchfifo_accept_data  = (rst || empty) ? '0
                                   : head_word[int'(lane_idx)*LANE_W +: LANE_W];

endmodule

// File: doc/prefetch_lane_fifo.md
PREFETCH_LANE_FIFO -- requirements
Module: prefetch_lane_fifo

Interface
REQ-001 Parameters SHALL be:
- LANES, default 2: 68-bit entries per written word.
- LANE_W, default 68: entry width; [LANE_W-1:64] is length/type, [63:0] is bytes.
- DEPTH_LOG2, default 4: the FIFO holds 2**DEPTH_LOG2 words.
REQ-002 Ports, clock and reset first (name / direction / width / meaning):
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pr_reset  in  1  synchronous flush.
- prefetchfifo_signal_limit_do  in  1  push a GP-fault entry.
- prefetchfifo_signal_pf_do  in  1  push a PF-fault entry.
- prefetchfifo_write_do  in  1  push a data word.
- prefetchfifo_write_data  in  LANES*LANE_W  lane k at bits [k*LANE_W +: LANE_W]; lane 0 is consumed first.
- prefetchfifo_write_lanes  in  $clog2(LANES+1)  number of valid lanes, counted from lane 0.
- prefetchfifo_used  out  DEPTH_LOG2+1  words stored.
- prefetchfifo_overflow  out  1  sticky: a push was dropped because the FIFO was full.
- prefetchfifo_fault_locked  out  1  a fault entry has been queued since the last flush.
- prefetchfifo_accept_do  in  1  consume the presented entry.
- prefetchfifo_accept_data  out  LANE_W  presented entry.
- prefetchfifo_accept_empty  out  1  no entry is presented.

Function
REQ-003 Push source priority SHALL be limit > pf > write; at most one word is pushed per cycle.
REQ-004 A fault push SHALL store lane 0 = {`PREFETCH_GP_FAULT or `PREFETCH_PF_FAULT, 64'd0}, all other lanes zero, with lane count 1.
REQ-005 write_do with write_lanes = 0 SHALL push nothing; values above LANES SHALL be clamped to LANES.
REQ-006 Each stored word SHALL carry its lane count; lanes at or above that count SHALL never be presented.
REQ-007 accept_data SHALL be lane lane_idx of the head word; accept_empty SHALL be 1 exactly when used = 0.
REQ-008 accept_do while not empty SHALL advance the lane:
- lane_idx < count-1: increment lane_idx.
- otherwise: pop the head word and set lane_idx to 0.
REQ-009 accept_do while empty SHALL have no effect.
REQ-010 Timing:
- A pushed word SHALL be presentable the cycle after the push.
- There is no combinational path from any write-side input to accept_data or accept_empty.
REQ-011 A push when used = 2**DEPTH_LOG2 SHALL be accepted if the same cycle pops the head word; otherwise it SHALL be dropped and overflow set.
REQ-012 A push with no pop SHALL increment used; a pop with no push SHALL decrement it; both together SHALL leave used unchanged.
REQ-013 Fault lock SHALL work as follows:
- After any fault push is accepted, fault_locked SHALL be 1.
- While fault_locked = 1, all further pushes (fault or write) SHALL be dropped silently, without setting overflow.
- Reads SHALL continue normally.
REQ-014 pr_reset SHALL clear used, lane_idx, overflow and fault_locked.
REQ-015 pr_reset SHALL override any push or accept in the same cycle.
REQ-016 Read and write pointers SHALL wrap modulo 2**DEPTH_LOG2.

Reset
REQ-017 While rst = 1, the following SHALL be forced asynchronously: used = 0, accept_empty = 1, overflow = 0, fault_locked = 0, lane_idx = 0, pointers = 0.
REQ-018 accept_data SHALL be 0 during reset.
REQ-019 Storage RAM contents SHALL need no reset.
REQ-020 Deasserting rst SHALL be safe mid-traffic: the first cycle after reset presents empty.

Structure
REQ-021 `PREFETCH_GP_FAULT, `PREFETCH_PF_FAULT and the 4-bit length/type field position SHALL come from the shared defines.v; no local copies.
REQ-022 Word storage SHALL be one sub-module, lane_fifo_ram:
- simple dual-port;
- depth 2**DEPTH_LOG2;
- width LANES*LANE_W + $clog2(LANES+1).
REQ-023 Lane sequencing, counters and flags SHALL live in prefetch_lane_fifo.

Verification (defaults unless noted)
REQ-024 Lane order: write_lanes = 2 with lane0 = A, lane1 = B, then accept on three consecutive cycles -> A, then B, then accept_empty = 1 and used = 0.
REQ-025 Partial word: write_lanes = 1 with lane1 = 0xFF.., then accept once -> A is presented and popped, the FIFO is empty, and lane1 is never presented.
REQ-026 Full plus overflow:
- 16 writes -> used = 16.
- A 17th write with no accept -> dropped, overflow = 1.
- A 17th write together with a last-lane accept -> accepted, used stays 16.
REQ-027 Fault lock:
- limit_do and write_do in the same cycle -> only the GP-fault entry is pushed, with [67:64] = `PREFETCH_GP_FAULT.
- A later write_do -> dropped, overflow stays 0, fault_locked = 1.
REQ-028 Flush: pr_reset with accept_do and write_do in the same cycle -> used = 0, flags 0, nothing pushed.
REQ-029 Async reset: rst pulsed mid-word, with no clock edge -> accept_empty = 1 immediately; with LANES = 4, DEPTH_LOG2 = 3 the regression reruns REQ-024..REQ-028 scaled to those parameters.
